// File: rtl/addsub_nibble_serial.sv
// Nibble-serial adder/subtractor: one 4-bit ripple slice per clock, LS nibble first,
// with the inter-nibble carry held in a register and the result assembled in place.
module addsub_nibble_serial #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] s,
    output logic                  cout,
    output logic                  ovf
);

    localparam int NIBBLES = DATA_WIDTH / 4;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int MSB     = DATA_WIDTH - 1;
    localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);

    generate
        if ((DATA_WIDTH % 4) != 0 || DATA_WIDTH < 8) begin : g_bad_width
            $error("addsub_nibble_serial: DATA_WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_s;
    logic                  r_carry;
    logic                  r_cout;
    logic                  r_ovf;
    logic [CW-1:0]         r_cnt;

    logic                  w_last;
    logic [3:0]            w_slice_a;
    logic [3:0]            w_slice_b;
    logic [3:0]            w_slice_sum;
    logic [4:0]            w_c;

    assign w_last    = (r_cnt == LAST_NIB);
    assign w_slice_a = r_a[{r_cnt, 2'b00} +: 4];
    assign w_slice_b = r_b[{r_cnt, 2'b00} +: 4];
    assign w_c[0]    = r_carry;

    // The 4-bit ripple-carry slice shared by every nibble of the operation.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            assign w_slice_sum[gi] = w_slice_a[gi] ^ w_slice_b[gi] ^ w_c[gi];
            assign w_c[gi+1]       = (w_slice_a[gi] & w_slice_b[gi])
                                   | (w_slice_a[gi] & w_c[gi])
                                   | (w_slice_b[gi] & w_c[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_next = S_RUN;
            S_RUN:   if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        // Subtraction as A + ~B + 1: B is inverted here, the +1 enters as carry-in.
                        r_a     <= a;
                        r_b     <= b ^ {DATA_WIDTH{sub}};
                        r_carry <= sub;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_s[{r_cnt, 2'b00} +: 4] <= w_slice_sum;
                    r_carry                  <= w_c[4];
                    r_cnt                    <= w_last ? '0 : r_cnt + 1'b1;
                    if (w_last) begin
                        r_cout <= w_c[4];
                        r_ovf  <= (r_a[MSB] == r_b[MSB]) && (w_slice_sum[3] != r_a[MSB]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = (r_state == S_DONE);
    assign s         = r_s;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_addsub_nibble_serial.sv
// Bench for addsub_nibble_serial: arithmetic reference model with a per-cycle compare
// process, plus directed operations with hand-computed results.
module tb_addsub_nibble_serial;

    localparam int DW      = 32;
    localparam int NIBBLES = DW / 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] s;
    logic          cout;
    logic          ovf;

    int checks = 0;
    int errors = 0;

    addsub_nibble_serial #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, returns {ovf, cout, s}.
    function automatic logic [DW+1:0] ref_op(input logic [DW-1:0] ra, input logic [DW-1:0] rb,
                                             input logic rsub);
        longint sa, sb, res, ua, ub;
        logic   c, o;
        sa  = longint'($signed(ra));
        sb  = longint'($signed(rb));
        ua  = longint'({32'd0, ra});
        ub  = longint'({32'd0, rb});
        res = rsub ? (sa - sb) : (sa + sb);
        o   = (res > 64'sd2147483647) || (res < -64'sd2147483648);
        c   = rsub ? (ua >= ub) : ((ua + ub) >= 64'sh1_0000_0000);
        return {o, c, res[DW-1:0]};
    endfunction

    // Model: idle / computing / done, with the expected result captured at acceptance.
    int            m_phase = 0;
    int            m_cnt   = 0;
    bit            m_live  = 1'b0;
    logic [DW-1:0] m_s;
    logic          m_cout;
    logic          m_ovf;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_live  <= 1'b1;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_phase                <= 1;
                    m_cnt                  <= 0;
                    {m_ovf, m_cout, m_s}   <= ref_op(a, b, sub);
                end
                1: begin
                    m_cnt <= m_cnt + 1;
                    if (m_cnt == NIBBLES - 1) m_phase <= 2;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("mdl_in_ready", {63'd0, in_ready}, {63'd0, (m_phase == 0) && !rst});
            chk("mdl_out_valid", {63'd0, out_valid}, {63'd0, m_phase == 2});
            if (m_phase == 2) begin
                chk("mdl_s", {32'd0, s}, {32'd0, m_s});
                chk("mdl_cout", {63'd0, cout}, {63'd0, m_cout});
                chk("mdl_ovf", {63'd0, ovf}, {63'd0, m_ovf});
            end
        end
    end

    task automatic run_op(input logic [DW-1:0] ta, input logic [DW-1:0] tb_, input logic tsub,
                          input logic [DW-1:0] es, input logic ec, input logic eo, input int stall);
        int            wait_n;
        int            lat;
        logic [DW-1:0] hs;
        logic          hc;
        logic          ho;
        wait_n = 0;
        while (!in_ready && wait_n < 20) begin
            @(posedge clk); #1;
            wait_n++;
        end
        chk("accept_ready", {63'd0, in_ready}, 64'd1);
        a = ta; b = tb_; sub = tsub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(NIBBLES));
        chk("s", {32'd0, s}, {32'd0, es});
        chk("cout", {63'd0, cout}, {63'd0, ec});
        chk("ovf", {63'd0, ovf}, {63'd0, eo});
        $display("op a=%08h b=%08h sub=%0d -> s=%08h cout=%0d ovf=%0d lat=%0d",
                 ta, tb_, tsub, s, cout, ovf, lat);
        hs = s; hc = cout; ho = ovf;
        for (int i = 0; i < stall; i++) begin
            a = $urandom; b = $urandom; sub = 1'(i); in_valid = 1'b1;
            @(posedge clk); #1;
            chk("stall_s", {32'd0, s}, {32'd0, hs});
            chk("stall_cout", {63'd0, cout}, {63'd0, hc});
            chk("stall_ovf", {63'd0, ovf}, {63'd0, ho});
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_out_valid", {63'd0, out_valid}, 64'd0);
        chk("release_in_ready", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_s", {32'd0, s}, 64'd0);
        chk("rst_cout", {63'd0, cout}, 64'd0);
        chk("rst_ovf", {63'd0, ovf}, 64'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        $display("reset released, in_ready=%0d", in_ready);

        run_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0);
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 5);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 2);

        // Abort an operation while nibble 3 is in the slice.
        a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_s", {32'd0, s}, 64'd0);
        chk("abort_cout", {63'd0, cout}, 64'd0);
        chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
        $display("mid-run reset: out_valid=%0d s=%08h", out_valid, s);
        repeat (NIBBLES + 2) begin
            @(posedge clk); #1;
        end
        chk("abort_no_result", {63'd0, out_valid}, 64'd0);

        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_nibble_serial.md
Name: addsub_nibble_serial

Overview:
- Multi-cycle wide adder/subtractor for the nroot datapath.
- Drives one 4-bit ripple-carry slice (the existing FA_4 cell, DATA_WIDTH=4) once per clock, least-significant nibble first.
- Registers the carry between nibbles and assembles the full-width result.
- Trades latency for area.
- Sits between the root-digit control logic (upstream, issues operand pairs) and the partial-remainder register (downstream, consumes the sum).

Parameters:
- DATA_WIDTH, 32, operand/result width in bits. Must be a multiple of 4 and at least 8; otherwise elaboration error.
- NIBBLES, DATA_WIDTH/4, derived and not overridable; number of slice cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept an operand pair
- a  input  DATA_WIDTH  operand A
- b  input  DATA_WIDTH  operand B
- sub  input  1  0: A+B; 1: A-B
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- s  output  DATA_WIDTH  sum/difference
- cout  output  1  carry out of the MSB. For subtraction: 1 means no borrow (A >= B unsigned).
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Single clock; synchronous active-high reset.
- States: IDLE, RUN, DONE.
- Reset values: state=IDLE, in_ready=0 while rst=1, out_valid=0, s=0, cout=0, ovf=0, nibble counter=0, carry reg=0.
- in_ready = 1 only in IDLE with rst=0.
- IDLE:
  - Acceptance occurs on an edge with in_valid=1 and in_ready=1.
  - On acceptance, latch a into A_reg and (b XOR {DATA_WIDTH{sub}}) into B_reg.
  - Load carry reg with sub; latch sub into sub_reg for the ovf computation.
  - Clear counter; go to RUN.
- RUN:
  - Each cycle, slice inputs are A_reg[4k+3:4k], B_reg[4k+3:4k] and the carry reg, where k = counter.
  - On the edge: write slice sum into s[4k+3:4k]; write slice cout into the carry reg; increment counter.
  - At k = NIBBLES-1, instead go to DONE and drive cout from the slice cout.
  - ovf = (A_reg[MSB] == B_reg[MSB]) && (s[MSB] != A_reg[MSB]), using the inverted B_reg for subtraction.
- Latency: out_valid rises exactly NIBBLES clock edges after the acceptance edge (8 edges at default). No early exit for zero operands.
- DONE:
  - out_valid=1; s, cout and ovf held stable until the handshake.
  - On an edge with out_ready=1, go to IDLE and drop out_valid.
  - out_ready=0 stalls indefinitely with outputs unchanged.
- Minimum issue interval: NIBBLES+2 cycles. No overlap of DONE with a new acceptance; in_ready=0 in DONE.
- Inputs a, b and sub are ignored outside the acceptance edge; changing them mid-RUN has no effect.
- Wrap-around: the result is modulo 2^DATA_WIDTH; the carry beyond the MSB appears only on cout.
- Reset mid-operation (RUN or DONE): abort. Next cycle: IDLE, all outputs at reset values, no partial result exposed.
- out_ready during IDLE or RUN is ignored.
- in_valid held high during RUN/DONE is not accepted until IDLE returns.

Test Plan:
- Reset then idle: assert rst 2 cycles with in_valid=1 -> in_ready=0 and out_valid=0 during reset; in_ready=1 on the first cycle after release.
- Add with wrap: a=0x00000001, b=0xFFFFFFFF, sub=0 -> after exactly 8 edges, out_valid=1, s=0x00000000, cout=1, ovf=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, sub=0 -> s=0x80000000, cout=0, ovf=1.
- Subtract with borrow: a=0x00000005, b=0x00000007, sub=1 -> s=0xFFFFFFFE, cout=0, ovf=0. Then a=0x80000000, b=0x00000001, sub=1 -> s=0x7FFFFFFF, cout=1, ovf=1.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE, toggling a/b/in_valid -> s, cout and ovf remain unchanged; in_ready=0. Raise out_ready -> IDLE next cycle; next operand accepted.
- Reset mid-RUN: assert rst at nibble 3 of a=0x12345678 + b=0x11111111 -> IDLE, out_valid=0, s=0. A fresh 0x12345678+0x11111111 then yields s=0x23456789, cout=0, ovf=0.
